// File: rtl/trig_pkg.sv
// Shared constants, step tables and FSM state encoding for the triangle/sawtooth
// stream analyzer.
package trig_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned DELTA_W  = SAMPLE_W + 1;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned N_SEL    = 4;

    localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = 16'sh8000;
    localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = 16'sh7FFF;

    // Indexed by dc_sel: the generator's per-sample rising and falling steps.
    localparam logic signed [DELTA_W-1:0] STEP_UP   [N_SEL] =
        '{17'sd2048, 17'sd1024, 17'sd512, 17'sd341};
    localparam logic signed [DELTA_W-1:0] STEP_DOWN [N_SEL] =
        '{17'sd292, 17'sd341, 17'sd512, 17'sd1024};

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_BOTTOM = 2'd1,
        ST_RISE   = 2'd2,
        ST_FALL   = 2'd3
    } state_t;

endpackage

// File: rtl/trig_analyzer_if.sv
// Sample stream in, period measurement out; master is the sample source.
interface trig_analyzer_if #(
    parameter int unsigned CNT_W = 16
);
    import trig_pkg::*;

    logic                       s_valid;
    logic signed [SAMPLE_W-1:0] s_data;
    logic [SEL_W-1:0]           dc_sel_det;
    logic [CNT_W-1:0]           period;
    logic                       locked;
    logic                       meas_valid;
    logic                       err;

    modport master (
        output s_valid, s_data,
        input  dc_sel_det, period, locked, meas_valid, err
    );

    modport slave (
        input  s_valid, s_data,
        output dc_sel_det, period, locked, meas_valid, err
    );

endinterface

// File: rtl/trig_step_decode.sv
// Combinational step lookup: rising delta -> {hit, dc_sel}; dc_sel -> steps.
module trig_step_decode
    import trig_pkg::*;
(
    input  logic signed [DELTA_W-1:0] delta,
    input  logic [SEL_W-1:0]          dc_sel,
    output logic                      up_hit_c,
    output logic [SEL_W-1:0]          up_sel_c,
    output logic signed [DELTA_W-1:0] step_up_c,
    output logic signed [DELTA_W-1:0] step_down_c
);

    always_comb begin
        up_hit_c    = 1'b0;
        up_sel_c    = '0;
        step_up_c   = STEP_UP[dc_sel];
        step_down_c = STEP_DOWN[dc_sel];
        for (int i = 0; i < N_SEL; i++) begin
            if (delta == STEP_UP[i]) begin
                up_hit_c = 1'b1;
                up_sel_c = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/trig_analyzer.sv
// Tracks a generator triangle stream, decodes its duty-cycle selection and
// measures the period in valid samples; flags any sample off the profile.
module trig_analyzer
    import trig_pkg::*;
#(
    parameter int unsigned CNT_W = 16
)(
    input  logic           clk,
    input  logic           rst,
    trig_analyzer_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                     state, state_nxt;
    logic signed [SAMPLE_W-1:0] prev_sample;
    logic [CNT_W-1:0]           period_cnt, cnt_nxt;
    logic [SEL_W-1:0]           dc_lat, lat_nxt;
    logic [SEL_W-1:0]           dc_det, det_nxt;
    logic [CNT_W-1:0]           period_q, period_nxt;
    logic                       locked_q, locked_nxt;
    logic                       meas_q, err_q;

    logic ev_start, ev_relatch, ev_count, ev_done, ev_abort, ev_err;
    logic signed [DELTA_W-1:0]  delta_c, step_up_c, step_down_c;
    logic                       up_hit_c;
    logic [SEL_W-1:0]           up_sel_c;
    logic                       is_min, is_max, cnt_sat, rise_clip, fall_done;

    assign delta_c = $signed({bus.s_data[SAMPLE_W-1], bus.s_data})
                   - $signed({prev_sample[SAMPLE_W-1], prev_sample});

    trig_step_decode u_dec (
        .delta       (delta_c),
        .dc_sel      (dc_lat),
        .up_hit_c    (up_hit_c),
        .up_sel_c    (up_sel_c),
        .step_up_c   (step_up_c),
        .step_down_c (step_down_c)
    );

    assign is_min    = (bus.s_data == SAMPLE_MIN);
    assign is_max    = (bus.s_data == SAMPLE_MAX);
    assign cnt_sat   = (period_cnt >= (CNT_MAX - CNT_W'(1)));
    // The last step at either rail is clipped, so it may be any size up to a full step.
    assign rise_clip = is_max && (delta_c >= 17'sd1) && (delta_c <= step_up_c);
    assign fall_done = is_min && (delta_c <= -17'sd1) && (delta_c >= -step_down_c);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_HUNT;
        else     state <= state_nxt;
    end

    // Next-state decision and the events it implies
    always_comb begin
        state_nxt  = state;
        ev_start   = 1'b0;
        ev_relatch = 1'b0;
        ev_count   = 1'b0;
        ev_done    = 1'b0;
        ev_abort   = 1'b0;
        ev_err     = 1'b0;
        if (bus.s_valid) begin
            case (state)
                ST_HUNT: begin
                    if (is_min) state_nxt = ST_BOTTOM;
                end
                ST_BOTTOM: begin
                    if (!is_min) begin
                        if (up_hit_c) begin
                            ev_start  = 1'b1;
                            state_nxt = ST_RISE;
                        end else begin
                            ev_err    = 1'b1;
                            state_nxt = ST_HUNT;
                        end
                    end
                end
                ST_RISE: begin
                    if (rise_clip) begin
                        ev_count  = 1'b1;
                        state_nxt = ST_FALL;
                    end else if (up_hit_c) begin
                        ev_count   = 1'b1;
                        ev_relatch = 1'b1;
                    end else if (is_min) begin
                        ev_abort  = 1'b1;
                        state_nxt = ST_BOTTOM;
                    end else begin
                        ev_err    = 1'b1;
                        state_nxt = ST_HUNT;
                    end
                end
                ST_FALL: begin
                    if (fall_done) begin
                        ev_done   = 1'b1;
                        state_nxt = ST_BOTTOM;
                    end else if (delta_c == -step_down_c) begin
                        ev_count = 1'b1;
                    end else begin
                        ev_err    = 1'b1;
                        state_nxt = ST_HUNT;
                    end
                end
                default: state_nxt = ST_HUNT;
            endcase
            if (ev_count && cnt_sat) begin
                ev_err    = 1'b1;
                state_nxt = ST_HUNT;
            end
        end
    end

    // Next values of the datapath and measurement outputs
    always_comb begin
        cnt_nxt    = period_cnt;
        lat_nxt    = dc_lat;
        det_nxt    = dc_det;
        period_nxt = period_q;
        locked_nxt = locked_q;
        if (ev_start) begin
            cnt_nxt = CNT_W'(1);
            lat_nxt = up_sel_c;
        end
        if (ev_count && (period_cnt != CNT_MAX)) cnt_nxt = period_cnt + CNT_W'(1);
        if (ev_relatch) lat_nxt = up_sel_c;
        if (ev_done) begin
            det_nxt    = dc_lat;
            period_nxt = period_cnt + CNT_W'(1);
            locked_nxt = 1'b1;
        end
        if (ev_err || ev_abort) locked_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_sample <= SAMPLE_MIN;
            period_cnt  <= '0;
            dc_lat      <= '0;
            dc_det      <= '0;
            period_q    <= '0;
            locked_q    <= 1'b0;
            meas_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (bus.s_valid) prev_sample <= bus.s_data;
            period_cnt <= cnt_nxt;
            dc_lat     <= lat_nxt;
            dc_det     <= det_nxt;
            period_q   <= period_nxt;
            locked_q   <= locked_nxt;
            meas_q     <= ev_done;
            err_q      <= ev_err;
        end
    end

    assign bus.dc_sel_det = dc_det;
    assign bus.period     = period_q;
    assign bus.locked     = locked_q;
    assign bus.meas_valid = meas_q;
    assign bus.err        = err_q;

endmodule

// File: doc/trig_analyzer.md
TRIG_ANALYZER -- requirements
Module: trig_analyzer

Interface
REQ-001 Parameter CNT_W, default 16: width of the period counter and the period output.
REQ-002 clk  in  1  clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset rst, synchronous, active-high.
REQ-004 s_valid  in  1  sample strobe, one sample per asserted cycle (generator clk_en rate).
REQ-005 s_data  in  16  signed triangle/sawtooth sample.
REQ-006 dc_sel_det  out  2  decoded duty-cycle selection of the last completed period.
REQ-007 period  out  CNT_W  valid samples in the last completed period.
REQ-008 locked  out  1  high while the stream matches the decoded profile.
REQ-009 meas_valid  out  1  one-cycle pulse when dc_sel_det/period update.
REQ-010 err  out  1  one-cycle pulse on a profile violation.

Function
REQ-011 The step tables SHALL be: dc_sel 00/01/10/11 -> step_up 2048/1024/512/341, step_down 292/341/512/1024.
REQ-012 On each s_valid cycle, delta = s_data - prev_sample SHALL be computed at 17-bit signed width; prev_sample updates on every valid sample; no state changes when s_valid=0.
REQ-013 The FSM SHALL have states HUNT, BOTTOM, RISE and FALL.
REQ-014 HUNT: a sample equal to -32768 SHALL move to BOTTOM; any other sample stays in HUNT.
REQ-015 BOTTOM: a sample equal to -32768 SHALL stay (generator disabled or idle).
REQ-016 BOTTOM: delta matching a step_up table entry SHALL latch that dc_sel, load period_cnt=1 and move to RISE.
REQ-017 BOTTOM: any other delta SHALL pulse err and move to HUNT.
REQ-018 RISE: s_data=32767 with 1 <= delta <= step_up (clipped final step) SHALL move to FALL.
REQ-019 RISE: delta=step_up SHALL stay.
REQ-020 RISE: s_data=-32768 SHALL abort to BOTTOM with locked cleared and no err.
REQ-021 RISE: anything else SHALL pulse err, clear locked and move to HUNT.
REQ-022 FALL: delta = -step_down(latched dc_sel) SHALL stay.
REQ-023 FALL: s_data=-32768 with -step_down <= delta <= -1 SHALL complete the period.
REQ-024 On period completion, dc_sel_det<=latched dc_sel, period<=period_cnt+1, meas_valid pulse, locked<=1, and the FSM moves to BOTTOM.
REQ-025 FALL: any other delta SHALL pulse err, clear locked and move to HUNT.
REQ-026 The period counter SHALL increment on every valid sample in RISE/FALL and saturate at 2^CNT_W-1; reaching saturation SHALL pulse err and move to HUNT.
REQ-027 All outputs SHALL be registered, updating on the clock edge after the deciding sample (latency 1 cycle).
REQ-028 meas_valid and err SHALL never be asserted in the same cycle.
REQ-029 In a locked period, a step_up that decodes to a different dc_sel SHALL re-latch the new value silently; dc_sel_det changes only at the next completion.

Reset
REQ-030 rst SHALL set state=HUNT, prev_sample=-32768, period_cnt=0, dc_sel_det=00, period=0, locked=0, meas_valid=0, err=0.
REQ-031 rst SHALL override s_valid in the same cycle, abort any period in progress and emit no pulse.

Structure
REQ-032 Package trig_pkg SHALL hold the step_up/step_down tables, the sample min/max constants and the FSM state enum.
REQ-033 Sub-module trig_step_decode SHALL be combinational: step_up value -> {hit, dc_sel}, and dc_sel -> step_down.

Verification
REQ-034 Generator stream, dc_sel=00: rise 32 samples, fall 225 samples -> meas_valid with dc_sel_det=00, period=257, locked=1.
REQ-035 Generator stream, dc_sel=10 -> period=256 (128 rising, 128 falling), dc_sel_det=10, meas_valid once per period.
REQ-036 Hold s_data=-32768 for 100 samples, then dc_sel=11 stream -> no err; first meas_valid reports dc_sel_det=11.
REQ-037 Inject s_data=0 mid-RISE with dc_sel=01 -> err pulse next cycle, locked=0; recovers with meas_valid after the next full period.
REQ-038 Force s_data=-32768 mid-RISE (dc dropped) -> locked=0, no err; s_valid low gaps cause no state change.
REQ-039 Assert rst mid-FALL -> all outputs reset next cycle, FSM in HUNT; no meas_valid until one full new period.
